// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin write arbiter and pointer/occupancy controller for a shared
// 64x8 dual-port FIFO RAM with a 1-cycle registered read port.
module fifo_rr_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    input  logic               rd_req,
    output logic               dout_valid,
    output logic [DW-1:0]      dout,
    output logic               ram_wr_en,
    output logic [AW-1:0]      ram_wr_addr,
    output logic [DW-1:0]      ram_wr_data,
    output logic               ram_rd_en,
    output logic [AW-1:0]      ram_rd_addr,
    input  logic [DW-1:0]      ram_rd_data,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand;
    logic          found;
    logic [AW:0]   count_next;
    logic [DW-1:0] din_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign din_arr[i] = din[i*DW +: DW];
    end

    // NOTE: every signal gets a default before any condition so no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        if (rst && !full) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = IW'((int'(rr_ptr) + k) % NREQ);
                if (!found && req[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (found) gnt[gnt_idx] = 1'b1;
        end
    end

    assign ram_wr_en   = |gnt;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = din_arr[gnt_idx];

    assign ram_rd_en   = rd_req & !empty & rst;
    assign ram_rd_addr = rd_ptr;
    assign dout        = ram_rd_data;

    // A simultaneous write and read leaves occupancy unchanged.
    always_comb begin
        count_next = count;
        case ({ram_wr_en, ram_rd_en})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: all state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rr_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            dout_valid <= 1'b0;
        end else begin
            if (ram_wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (ram_rd_en) rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            full       <= (count_next == (AW+1)'(DEPTH));
            empty      <= (count_next == '0);
            dout_valid <= ram_rd_en;
        end
    end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Self-checking bench: behavioural RAM, expected-data queue popped on dout_valid,
// and an occupancy/pointer model advanced by the writes/reads each test predicts.
module tb_fifo_rr_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic               rd_req;
    logic               dout_valid;
    logic [DW-1:0]      dout;
    logic               ram_wr_en;
    logic [AW-1:0]      ram_wr_addr;
    logic [DW-1:0]      ram_wr_data;
    logic               ram_rd_en;
    logic [AW-1:0]      ram_rd_addr;
    logic [DW-1:0]      ram_rd_data;
    logic               full;
    logic               empty;
    logic [AW:0]        count;

    fifo_rr_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt),
        .rd_req(rd_req), .dout_valid(dout_valid), .dout(dout),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    int            n_vec = 0;
    int            n_err = 0;
    int            exp_count = 0;
    logic [AW-1:0] exp_wr = '0;
    logic [AW-1:0] exp_rd = '0;
    logic [DW-1:0] sb_q [$];

    // One clock; w/r are the write/read this test expects the DUT to perform.
    task automatic step(input bit w, input bit r);
        logic [DW-1:0] e;
        @(posedge clk);
        #1;
        if (w) begin exp_count++; exp_wr = exp_wr + 1'b1; end
        if (r) begin exp_count--; exp_rd = exp_rd + 1'b1; end
        n_vec++;
        if (dout_valid !== r) begin
            n_err++;
            $display("FAIL dout_valid: got %b want %b", dout_valid, r);
        end
        if (dout_valid === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL dout_spurious: got %h want no word", dout);
            end else begin
                e = sb_q.pop_front();
                if (dout !== e) begin
                    n_err++;
                    $display("FAIL dout: got %h want %h", dout, e);
                end
            end
        end
        n_vec++;
        if (count !== 7'(exp_count) || full !== (exp_count == 64) || empty !== (exp_count == 0)) begin
            n_err++;
            $display("FAIL occupancy: got count=%0d full=%b empty=%b want count=%0d", count, full, empty, exp_count);
        end
    endtask

    task automatic write_port(input int p, input logic [DW-1:0] d);
        req = 4'(1 << p);
        din[p*DW +: DW] = d;
        #1;
        n_vec++;
        if (gnt !== 4'(1 << p) || ram_wr_data !== d || ram_wr_addr !== exp_wr) begin
            n_err++;
            $display("FAIL write_p%0d: got gnt=%b data=%h addr=%0d want gnt=%b data=%h addr=%0d",
                     p, gnt, ram_wr_data, ram_wr_addr, 4'(1 << p), d, exp_wr);
        end
        sb_q.push_back(d);
        step(1'b1, 1'b0);
        req = '0;
    endtask

    task automatic drain(input int n);
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            n_vec++;
            if (ram_rd_en !== 1'b1 || ram_rd_addr !== exp_rd) begin
                n_err++;
                $display("FAIL drain_rd: got en=%b addr=%0d want en=1 addr=%0d", ram_rd_en, ram_rd_addr, exp_rd);
            end
            step(1'b0, 1'b1);
        end
        rd_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_count = 0;
        exp_wr = '0;
        exp_rd = '0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b1111;
        rd_req = 1'b0;
        din = '0;
        @(posedge clk);
        #2;
        n_vec++;
        if (gnt !== 4'b0000 || ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gate: got gnt=%b wr_en=%b rd_en=%b want 0000 0 0", gnt, ram_wr_en, ram_rd_en);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        #1;
        n_vec++;
        if (gnt !== 4'b0000 || empty !== 1'b1 || full !== 1'b0 || count !== 7'd0 || dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got gnt=%b empty=%b full=%b count=%0d dv=%b want 0000 1 0 0 0",
                     gnt, empty, full, count, dout_valid);
        end
        rd_req = 1'b1;
        #1;
        n_vec++;
        if (ram_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL read_empty_en: got %b want 0", ram_rd_en);
        end
        step(1'b0, 1'b0);
        rd_req = 1'b0;
        #1;
        n_vec++;
        if (ram_rd_addr !== 6'd0) begin
            n_err++;
            $display("FAIL read_empty_ptr: got %0d want 0", ram_rd_addr);
        end
    endtask

    task automatic test_rr_order();
        for (int p = 0; p < NREQ; p++) din[p*DW +: DW] = 8'h10 + 8'(p);
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_vec++;
            if (gnt !== 4'(1 << (c % 4)) || ram_wr_en !== 1'b1 || ram_wr_addr !== 6'(c)
                || ram_wr_data !== 8'h10 + 8'(c % 4)) begin
                n_err++;
                $display("FAIL rr_cycle%0d: got gnt=%b addr=%0d data=%h want gnt=%b addr=%0d data=%h",
                         c, gnt, ram_wr_addr, ram_wr_data, 4'(1 << (c % 4)), c, 8'h10 + 8'(c % 4));
            end
            sb_q.push_back(8'h10 + 8'(c % 4));
            step(1'b1, 1'b0);
        end
        req = '0;
        for (int a = 0; a < 8; a++) begin
            n_vec++;
            if (mem[a] !== 8'h10 + 8'(a % 4)) begin
                n_err++;
                $display("FAIL rr_mem%0d: got %h want %h", a, mem[a], 8'h10 + 8'(a % 4));
            end
        end
        drain(8);
    endtask

    task automatic test_full();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 64; c++) begin
            din[2*DW +: DW] = 8'h40 + 8'(c);
            #1;
            n_vec++;
            if (gnt !== 4'b0100 || ram_wr_addr !== 6'(c)) begin
                n_err++;
                $display("FAIL fill%0d: got gnt=%b addr=%0d want 0100 %0d", c, gnt, ram_wr_addr, c);
            end
            sb_q.push_back(8'h40 + 8'(c));
            step(1'b1, 1'b0);
        end
        for (int s = 0; s < 2; s++) begin
            #1;
            n_vec++;
            if (gnt !== 4'b0000 || ram_wr_en !== 1'b0) begin
                n_err++;
                $display("FAIL full_stall: got gnt=%b wr_en=%b want 0000 0", gnt, ram_wr_en);
            end
            step(1'b0, 1'b0);
        end
        rd_req = 1'b1;
        #1;
        n_vec++;
        if (gnt !== 4'b0000 || ram_rd_en !== 1'b1) begin
            n_err++;
            $display("FAIL full_read_nobypass: got gnt=%b rd_en=%b want 0000 1", gnt, ram_rd_en);
        end
        step(1'b0, 1'b1);
        rd_req = 1'b0;
        din[2*DW +: DW] = 8'hEE;
        #1;
        n_vec++;
        if (gnt !== 4'b0100 || ram_wr_addr !== 6'd0) begin
            n_err++;
            $display("FAIL full_resume: got gnt=%b addr=%0d want 0100 0", gnt, ram_wr_addr);
        end
        sb_q.push_back(8'hEE);
        step(1'b1, 1'b0);
        req = '0;
        drain(64);
    endtask

    task automatic test_read_latency();
        write_port(0, 8'hAA);
        write_port(0, 8'hCC);
        write_port(0, 8'hFF);
        rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            if (ram_rd_en !== (k < 3)) begin
                n_err++;
                $display("FAIL rd_en%0d: got %b want %b", k, ram_rd_en, k < 3);
            end
            step(1'b0, k < 3);
        end
        rd_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] w0;
        logic [AW-1:0] r0;
        for (int i = 0; i < 10; i++) write_port(1, 8'h60 + 8'(i));
        w0 = exp_wr;
        r0 = exp_rd;
        req = 4'b0010;
        rd_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din[1*DW +: DW] = 8'h80 + 8'(i);
            #1;
            n_vec++;
            if (gnt !== 4'b0010 || ram_rd_en !== 1'b1) begin
                n_err++;
                $display("FAIL b2b%0d: got gnt=%b rd_en=%b want 0010 1", i, gnt, ram_rd_en);
            end
            sb_q.push_back(8'h80 + 8'(i));
            step(1'b1, 1'b1);
        end
        req = '0;
        rd_req = 1'b0;
        #1;
        n_vec++;
        if (ram_wr_addr !== w0 + 6'd20 || ram_rd_addr !== r0 + 6'd20) begin
            n_err++;
            $display("FAIL b2b_ptrs: got wr=%0d rd=%0d want wr=%0d rd=%0d",
                     ram_wr_addr, ram_rd_addr, w0 + 6'd20, r0 + 6'd20);
        end
        drain(10);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 30; i++) write_port(0, 8'(i * 3));
        rd_req = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst = 1'b0;
        req = 4'b1001;
        #1;
        n_vec++;
        if (ram_rd_en !== 1'b0 || gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset_gate: got rd_en=%b gnt=%b want 0 0000", ram_rd_en, gnt);
        end
        @(posedge clk);
        #1;
        exp_count = 0;
        exp_wr = '0;
        exp_rd = '0;
        sb_q.delete();
        n_vec++;
        if (count !== 7'd0 || empty !== 1'b1 || full !== 1'b0 || dout_valid !== 1'b0
            || ram_wr_addr !== 6'd0 || ram_rd_addr !== 6'd0) begin
            n_err++;
            $display("FAIL mid_reset_state: got count=%0d empty=%b full=%b dv=%b wr=%0d rd=%0d want 0 1 0 0 0 0",
                     count, empty, full, dout_valid, ram_wr_addr, ram_rd_addr);
        end
        rst = 1'b1;
        rd_req = 1'b0;
        #1;
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_reset_rr: got %b want 0001", gnt);
        end
        req = 4'b1000;
        din[3*DW +: DW] = 8'h5A;
        #1;
        n_vec++;
        if (gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL mid_reset_p3: got %b want 1000", gnt);
        end
        sb_q.push_back(8'h5A);
        step(1'b1, 1'b0);
        req = '0;
        drain(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rr_order();
        test_full();
        test_read_latency();
        test_back_to_back();
        test_mid_reset();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d words want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
